joy_input_cond: RTL

Conditions raw controller inputs before the game-port (0x201) joystick block.
- Debounces the 14-bit digital vectors per player.
- Applies optional per-button autofire.
- Applies a deadzone to the signed 8-bit analog axes.
- Generates the free-running Gravis GamePad Pro serial clock.
- Outputs drive the joystick block's dig_1/dig_2/ana_1/ana_2/clk_grav inputs directly.

---
 rtl/joy_pkg.sv | 38 +++
 rtl/joy_debounce.sv | 57 +++++
 rtl/joy_input_cond.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/joy_pkg.sv
// Shared constants for the joystick input conditioning block: button indices,
// vector widths, the Gravis mode code and default divider values.
package joy_pkg;

  localparam int JOY_RIGHT  = 0;
  localparam int JOY_LEFT   = 1;
  localparam int JOY_DOWN   = 2;
  localparam int JOY_UP     = 3;
  localparam int JOY_BUT1   = 4;
  localparam int JOY_BUT2   = 5;
  localparam int JOY_BUT3   = 6;
  localparam int JOY_BUT4   = 7;
  localparam int JOY_START  = 8;
  localparam int JOY_SELECT = 9;
  localparam int JOY_R1     = 10;
  localparam int JOY_L1     = 11;
  localparam int JOY_R2     = 12;
  localparam int JOY_L2     = 13;

  localparam int JOY_DIG_W = 14;
  localparam int JOY_ANA_W = 16;

  localparam logic [1:0] JOY_MODE_GRAVIS = 2'd2;

  localparam int unsigned JOY_DB_DIV_DEF     = 90500;
  localparam int unsigned JOY_DB_COUNT_DEF   = 3;
  localparam int unsigned JOY_DEADZONE_DEF   = 8;
  localparam int unsigned JOY_GRAV_HALF_DEF  = 2262;
  localparam int unsigned JOY_TURBO_HALF_DEF = 4525000;

  typedef logic [JOY_DIG_W-1:0] joy_dig_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/joy_debounce.sv
// Whole-vector button debouncer: a changed vector must stay identical for
// DB_COUNT shared prescaler ticks before it replaces the stable vector.
module joy_debounce
  import joy_pkg::*;
#(
  parameter int unsigned DB_COUNT = JOY_DB_COUNT_DEF
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     tick_i,
  input  joy_dig_t raw_i,
  output joy_dig_t stable_o
);

  localparam logic [3:0] DB_LIM = 4'(DB_COUNT);

  joy_dig_t   cand_q, cand_d;
  joy_dig_t   stable_q, stable_d;
  logic [3:0] cnt_q, cnt_d;

  // A raw change always restarts the count, even on a tick cycle.
  always_comb begin
    cand_d   = cand_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (raw_i != cand_q) begin
      cand_d = raw_i;
      cnt_d  = '0;
    end else if (raw_i != stable_q) begin
      if (tick_i) begin
        if (cnt_q + 4'd1 == DB_LIM) begin
          stable_d = cand_q;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      cand_q   <= cand_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/joy_input_cond.sv
// Raw controller conditioning for the game-port joystick block: debounce,
// optional autofire (enabled by defining JOY_AUTOFIRE_EN), analog deadzone
// and the free-running Gravis GamePad Pro serial clock.
module joy_input_cond
  import joy_pkg::*;
#(
  parameter int unsigned DB_DIV     = JOY_DB_DIV_DEF,
  parameter int unsigned DB_COUNT   = JOY_DB_COUNT_DEF,
  parameter int unsigned DEADZONE   = JOY_DEADZONE_DEF,
  parameter int unsigned GRAV_HALF  = JOY_GRAV_HALF_DEF,
  parameter int unsigned TURBO_HALF = JOY_TURBO_HALF_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [JOY_DIG_W-1:0] joy_raw_1,
  input  logic [JOY_DIG_W-1:0] joy_raw_2,
  input  logic [JOY_ANA_W-1:0] ana_raw_1,
  input  logic [JOY_ANA_W-1:0] ana_raw_2,
  input  logic [1:0]           mode,
  input  logic [3:0]           turbo_mask,
  output logic [JOY_DIG_W-1:0] dig_1,
  output logic [JOY_DIG_W-1:0] dig_2,
  output logic [JOY_ANA_W-1:0] ana_1,
  output logic [JOY_ANA_W-1:0] ana_2,
  output logic                 clk_grav
);

  localparam int unsigned DB_W = cnt_w(DB_DIV);
  localparam int unsigned GV_W = cnt_w(GRAV_HALF);
  localparam logic [6:0]  DZ   = 7'(DEADZONE);

  // ---------------------------------------------------------------------------
  // Shared debounce prescaler and per-player debouncers
  // ---------------------------------------------------------------------------
  logic [DB_W-1:0] pre_q;
  logic            tick;
  joy_dig_t        stable_1, stable_2;

  assign tick = (pre_q == DB_W'(DB_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    pre_q <= '0;
    else if (tick) pre_q <= '0;
    else           pre_q <= pre_q + DB_W'(1);
  end

  joy_debounce #(.DB_COUNT(DB_COUNT)) u_db_1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick_i   (tick),
    .raw_i    (joy_raw_1),
    .stable_o (stable_1)
  );

  joy_debounce #(.DB_COUNT(DB_COUNT)) u_db_2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick_i   (tick),
    .raw_i    (joy_raw_2),
    .stable_o (stable_2)
  );

  // ---------------------------------------------------------------------------
  // Autofire and digital output register
  // ---------------------------------------------------------------------------
  joy_dig_t dig_1_d, dig_2_d, dig_1_q, dig_2_q;

`ifdef JOY_AUTOFIRE_EN
  localparam int unsigned TB_W = cnt_w(TURBO_HALF);

  logic [TB_W-1:0] turbo_cnt_q;
  logic            turbo_phase_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      turbo_cnt_q   <= '0;
      turbo_phase_q <= 1'b1;
    end else if (turbo_cnt_q == TB_W'(TURBO_HALF - 1)) begin
      turbo_cnt_q   <= '0;
      turbo_phase_q <= ~turbo_phase_q;
    end else begin
      turbo_cnt_q   <= turbo_cnt_q + TB_W'(1);
    end
  end

  function automatic joy_dig_t apply_turbo(input joy_dig_t s, input logic [3:0] m,
                                           input logic ph);
    joy_dig_t r;
    r = s;
    for (int i = 0; i < 4; i++) begin
      r[JOY_BUT1+i] = s[JOY_BUT1+i] & (~m[i] | ph);
    end
    return r;
  endfunction

  assign dig_1_d = apply_turbo(stable_1, turbo_mask, turbo_phase_q);
  assign dig_2_d = apply_turbo(stable_2, turbo_mask, turbo_phase_q);
`else
  logic unused_turbo_mask;

  assign unused_turbo_mask = ^turbo_mask;
  assign dig_1_d           = stable_1;
  assign dig_2_d           = stable_2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_1_q <= '0;
      dig_2_q <= '0;
    end else begin
      dig_1_q <= dig_1_d;
      dig_2_q <= dig_2_d;
    end
  end

  assign dig_1 = dig_1_q;
  assign dig_2 = dig_2_q;

  // ---------------------------------------------------------------------------
  // Analog deadzone pipeline, axes ordered P1.X, P1.Y, P2.X, P2.Y
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] abs_sat(input logic signed [7:0] v);
    if (v == 8'sh80) return 7'd127;
    else if (v[7])   return 7'(-v);
    else             return v[6:0];
  endfunction

  // Rebuilding from sign and saturated magnitude turns -128 into -127.
  function automatic logic signed [7:0] dz_apply(input logic sgn, input logic [6:0] mag);
    if (mag < DZ)  return 8'sd0;
    else if (sgn)  return -$signed({1'b0, mag});
    else           return $signed({1'b0, mag});
  endfunction

  logic signed [7:0] ax_p0 [4];
  logic              sign_p1_q [4];
  logic [6:0]        mag_p1_q [4];
  logic signed [7:0] ax_p2_q [4];

  assign ax_p0[0] = ana_raw_1[7:0];
  assign ax_p0[1] = ana_raw_1[15:8];
  assign ax_p0[2] = ana_raw_2[7:0];
  assign ax_p0[3] = ana_raw_2[15:8];

  // p0 -> p1: sign and saturated magnitude
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        sign_p1_q[i] <= 1'b0;
        mag_p1_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        sign_p1_q[i] <= ax_p0[i][7];
        mag_p1_q[i]  <= abs_sat(ax_p0[i]);
      end
    end
  end

  // p1 -> p2: deadzone and output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) ax_p2_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) ax_p2_q[i] <= dz_apply(sign_p1_q[i], mag_p1_q[i]);
    end
  end

  assign ana_1 = {ax_p2_q[1], ax_p2_q[0]};
  assign ana_2 = {ax_p2_q[3], ax_p2_q[2]};

  // ---------------------------------------------------------------------------
  // Gravis serial clock, held low and re-phased whenever mode leaves Gravis
  // ---------------------------------------------------------------------------
  logic [GV_W-1:0] grav_cnt_q;
  logic            clk_grav_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grav_cnt_q <= '0;
      clk_grav_q <= 1'b0;
    end else if (mode != JOY_MODE_GRAVIS) begin
      grav_cnt_q <= '0;
      clk_grav_q <= 1'b0;
    end else if (grav_cnt_q == GV_W'(GRAV_HALF - 1)) begin
      grav_cnt_q <= '0;
      clk_grav_q <= ~clk_grav_q;
    end else begin
      grav_cnt_q <= grav_cnt_q + GV_W'(1);
    end
  end

  assign clk_grav = clk_grav_q;

endmodule
